id_ctrl_stage: RTL and testbench
================================

// Module: id_ctrl_stage
// PURPOSE
//  Decode-side partner of the fetch stage. Holds the IF/ID pipeline register
//  and decodes control transfers (J, JAL, JR, BEQ, BNE). Drives the redirect
//  flags, targets and PC_EN back to fetch, and detects load-use and
//  branch-operand hazards.
//  Sits between fetch and EX. All PC values are word indices.
// PARAMETERS
//  ADDR_WIDTH  5   fetch PC width; targets are truncated to these bits, upper bits zero
//  CNT_W       16  width of the saturating bubble counter
// PORTS
//  clk          in   1   rising-edge clock
//  CLR          in   1   reset, synchronous, active-high
//  IR           in   32  instruction from fetch
//  PC_in        in   32  fetch PC of IR
//  rs_data      in   32  forwarded register value for id_ir[25:21]
//  rt_data      in   32  forwarded register value for id_ir[20:16]
//  ex_mem_read  in   1   EX instruction is a load
//  ex_reg_write in   1   EX instruction writes a register
//  ex_rd        in   5   EX destination register (rt for loads)
//  mem_mem_read in   1   MEM instruction is a load
//  mem_rd       in   5   MEM destination register
//  PC_EN        out  1   fetch may advance
//  J, JAL, JR   out  1   taken jump of that kind this cycle
//  Branch       out  1   taken BEQ/BNE this cycle
//  Jaddr        out  32  target for J/JAL/JR
//  PC_branch    out  32  id_pc + 1 + sext(imm16), truncated to ADDR_WIDTH
//  id_ir        out  32  IF/ID instruction register
//  id_pc        out  32  IF/ID PC register
//  id_valid     out  1   id_ir holds a real instruction
//  ex_bubble    out  1   EX must load a NOP this cycle
//  bubble_cnt   out  CNT_W  saturating count of inserted bubbles
// BEHAVIOUR
//  Reset (CLR=1 at posedge): id_ir=0, id_pc=0, id_valid=0, bubble_cnt=0,
//   state=RUN. CLR has priority over all other inputs.
//  Decode (only when id_valid=1):
//   opcode=id_ir[31:26], funct=id_ir[5:0]
//   J=0x02, JAL=0x03, JR=op 0 with funct 0x08, BEQ=0x04, BNE=0x05
//  Source use:
//   rs is used by every opcode except J, JAL and LUI(0x0F).
//   rt is used by op 0, BEQ, BNE and SW(0x2B).
//   Register 0 never creates a hazard.
//  Hazard (combinational): any one of
//   (a) ex_mem_read & ex_rd matches a used source
//   (b) current op is BEQ/BNE/JR & ex_reg_write & ex_rd matches a used source
//   (c) current op is BEQ/BNE/JR & mem_mem_read & mem_rd matches a used source
//  While hazard=1:
//   PC_EN=0; IF/ID register holds; ex_bubble=1; all redirect flags forced 0.
//  Redirect (hazard=0):
//   J/JAL: Jaddr = zero-extended id_ir[ADDR_WIDTH-1:0]
//   JR:    Jaddr = rs_data[ADDR_WIDTH-1:0]
//   BEQ taken iff rs_data==rt_data; BNE taken iff they differ.
//   Jaddr=0 when no jump is taken. PC_branch is always driven.
//  Next IF/ID load (PC_EN=1, no hazard):
//   No redirect: id_ir<=IR, id_pc<=PC_in, id_valid<=1.
//   Taken redirect: the wrong-path IR is squashed, giving id_valid<=0 and
//   id_ir<=0. There is no delay slot. Fetch loads the target on the same edge.
//  FSM (state, derived flags):
//   RUN -> STALL on hazard.
//   RUN -> FLUSH on taken redirect.
//   STALL -> STALL while hazard; otherwise as RUN.
//   FLUSH -> RUN, since id_valid=0 makes hazard and redirect impossible.
//  Invariants: PC_EN = ~hazard. At most one of J, JAL, JR, Branch is high.
//  bubble_cnt: +1 on every cycle with ex_bubble=1; saturates at all-ones.
//  Reset mid-stall or mid-flush: the next cycle is RUN with id_valid=0.
// TESTING
//  1 CLR=1 two cycles, then IR=0x2001_0005 (addi) at PC 0
//    -> id_valid=1, id_ir=0x20010005, PC_EN=1, all flags 0
//  2 id_ir=0x0800_0010 (J 16)
//    -> J=1, Jaddr=16 for one cycle; next cycle id_valid=0, state FLUSH
//  3 id_ir=BEQ $1,$2,-2 at id_pc=8 with rs_data=rt_data=7
//    -> Branch=1, PC_branch=7; with rt_data=8 -> Branch=0, PC_BRANCH unused
//  4 ex_mem_read=1, ex_rd=3, id_ir=add $4,$3,$5
//    -> PC_EN=0, ex_bubble=1, id_ir held, bubble_cnt+1
//  5 id_ir=JR $3 with ex_mem_read=1, ex_rd=3, then mem_mem_read=1, mem_rd=3
//    -> two stall cycles, then JR=1 and Jaddr=rs_data[4:0]
//  6 ex_mem_read=1, ex_rd=0, id_ir uses $0
//    -> no stall; separately, force 2^16 bubbles -> bubble_cnt stays 0xFFFF

Source files
------------

// File: rtl/id_ctrl_stage.sv
// id_ctrl_stage: IF/ID pipeline register, control-transfer decode and
// load-use / branch-operand hazard detection for the fetch stage.
//
// state | meaning
// RUN   | normal decode, IF/ID loads every cycle
// STALL | hazard held IF/ID last cycle, EX received a bubble
// FLUSH | a taken redirect squashed the wrong-path fetch
module id_ctrl_stage #(
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic [31:0]      IR,
    input  logic [31:0]      PC_in,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [4:0]       ex_rd,
    input  logic             mem_mem_read,
    input  logic [4:0]       mem_rd,
    output logic             PC_EN,
    output logic             J,
    output logic             JAL,
    output logic             JR,
    output logic             Branch,
    output logic [31:0]      Jaddr,
    output logic [31:0]      PC_branch,
    output logic [31:0]      id_ir,
    output logic [31:0]      id_pc,
    output logic             id_valid,
    output logic             ex_bubble,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t state, state_next;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs_addr;
    logic [4:0] rt_addr;
    logic       is_j, is_jal, is_jr, is_beq, is_bne, ctl_op;
    logic       rs_used, rt_used;
    logic       ex_hit, mem_hit;
    logic       hazard;
    logic       taken;
    logic [ADDR_WIDTH-1:0] br_lo;

    assign opcode  = id_ir[31:26];
    assign funct   = id_ir[5:0];
    assign rs_addr = id_ir[25:21];
    assign rt_addr = id_ir[20:16];

    // Instruction class and source-register usage of the IF/ID instruction.
    always_comb begin
        is_j    = id_valid && (opcode == OP_J);
        is_jal  = id_valid && (opcode == OP_JAL);
        is_jr   = id_valid && (opcode == OP_RTYPE) && (funct == FN_JR);
        is_beq  = id_valid && (opcode == OP_BEQ);
        is_bne  = id_valid && (opcode == OP_BNE);
        ctl_op  = is_beq || is_bne || is_jr;
        rs_used = id_valid && (opcode != OP_J) && (opcode != OP_JAL) && (opcode != OP_LUI);
        rt_used = id_valid && ((opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                               (opcode == OP_BNE) || (opcode == OP_SW));
    end

    // Register 0 is hard-wired, so it never participates in a dependency.
    always_comb begin
        ex_hit  = (rs_used && (rs_addr != 5'd0) && (rs_addr == ex_rd)) ||
                  (rt_used && (rt_addr != 5'd0) && (rt_addr == ex_rd));
        mem_hit = (rs_used && (rs_addr != 5'd0) && (rs_addr == mem_rd)) ||
                  (rt_used && (rt_addr != 5'd0) && (rt_addr == mem_rd));
        hazard  = (ex_mem_read && ex_hit) ||
                  (ctl_op && ex_reg_write && ex_hit) ||
                  (ctl_op && mem_mem_read && mem_hit);
    end

    // Redirect flags and targets; all redirects are suppressed while stalled.
    always_comb begin
        J         = 1'b0;
        JAL       = 1'b0;
        JR        = 1'b0;
        Branch    = 1'b0;
        Jaddr     = 32'd0;
        PC_EN     = ~hazard;
        ex_bubble = hazard;
        br_lo     = id_pc[ADDR_WIDTH-1:0] + id_ir[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
        PC_branch = {{(32-ADDR_WIDTH){1'b0}}, br_lo};
        if (!hazard) begin
            J      = is_j;
            JAL    = is_jal;
            JR     = is_jr;
            Branch = (is_beq && (rs_data == rt_data)) || (is_bne && (rs_data != rt_data));
            if (is_j || is_jal)
                Jaddr = {{(32-ADDR_WIDTH){1'b0}}, id_ir[ADDR_WIDTH-1:0]};
            else if (is_jr)
                Jaddr = {{(32-ADDR_WIDTH){1'b0}}, rs_data[ADDR_WIDTH-1:0]};
        end
        taken = J || JAL || JR || Branch;
    end

    // Next-state: stalls take priority since a stalled cycle cannot redirect.
    always_comb begin
        state_next = state;
        case (state)
            RUN, STALL: begin
                if (hazard)     state_next = STALL;
                else if (taken) state_next = FLUSH;
                else            state_next = RUN;
            end
            FLUSH:   state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (CLR) state <= RUN;
        else     state <= state_next;
    end

    // IF/ID register: hold on hazard, squash on redirect, else load fetch.
    always_ff @(posedge clk) begin
        if (CLR) begin
            id_ir    <= 32'd0;
            id_pc    <= 32'd0;
            id_valid <= 1'b0;
        end else if (!hazard) begin
            id_pc <= PC_in;
            if (taken) begin
                id_ir    <= 32'd0;
                id_valid <= 1'b0;
            end else begin
                id_ir    <= IR;
                id_valid <= 1'b1;
            end
        end
    end

    // Saturating count of bubbles handed to EX.
    always_ff @(posedge clk) begin
        if (CLR)
            bubble_cnt <= '0;
        else if (ex_bubble && (bubble_cnt != {CNT_W{1'b1}}))
            bubble_cnt <= bubble_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Bench for id_ctrl_stage: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a behavioural model.
module tb_id_ctrl_stage;

    logic        clk = 1'b0;
    logic        CLR;
    logic [31:0] IR, PC_in, rs_data, rt_data;
    logic        ex_mem_read, ex_reg_write, mem_mem_read;
    logic [4:0]  ex_rd, mem_rd;
    logic        PC_EN, J, JAL, JR, Branch, id_valid, ex_bubble;
    logic [31:0] Jaddr, PC_branch, id_ir, id_pc;
    logic [15:0] bubble_cnt;

    id_ctrl_stage #(.ADDR_WIDTH(5), .CNT_W(16)) dut (
        .clk(clk), .CLR(CLR), .IR(IR), .PC_in(PC_in),
        .rs_data(rs_data), .rt_data(rt_data),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
        .PC_EN(PC_EN), .J(J), .JAL(JAL), .JR(JR), .Branch(Branch),
        .Jaddr(Jaddr), .PC_branch(PC_branch), .id_ir(id_ir), .id_pc(id_pc),
        .id_valid(id_valid), .ex_bubble(ex_bubble), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // model state
    logic [31:0] m_ir, m_pc;
    logic        m_valid;
    int          m_bub;
    // model outputs
    logic        e_hz, e_j, e_jal, e_jr, e_br;
    logic [31:0] e_jaddr, e_pcb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        logic [5:0]  op;
        logic [4:0]  used[$];
        logic        ctl;
        int          tgt;
        op     = m_ir[31:26];
        e_hz   = 1'b0;
        e_j    = 1'b0; e_jal = 1'b0; e_jr = 1'b0; e_br = 1'b0;
        e_jaddr = 32'd0;
        tgt    = int'(m_pc) + 1 + int'($signed(m_ir[15:0]));
        e_pcb  = 32'(tgt & 31);
        if (m_valid) begin
            if (!(op == 6'h02 || op == 6'h03 || op == 6'h0F)) used.push_back(m_ir[25:21]);
            if (op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2B) used.push_back(m_ir[20:16]);
            ctl = (op == 6'h04) || (op == 6'h05) || (op == 6'h00 && m_ir[5:0] == 6'h08);
            foreach (used[i]) begin
                if (used[i] != 5'd0) begin
                    if (ex_mem_read && used[i] == ex_rd) e_hz = 1'b1;
                    if (ctl && ex_reg_write && used[i] == ex_rd) e_hz = 1'b1;
                    if (ctl && mem_mem_read && used[i] == mem_rd) e_hz = 1'b1;
                end
            end
            if (!e_hz) begin
                case (op)
                    6'h02: begin e_j = 1'b1;   e_jaddr = 32'(m_ir % 32); end
                    6'h03: begin e_jal = 1'b1; e_jaddr = 32'(m_ir % 32); end
                    6'h04: e_br = (rs_data == rt_data);
                    6'h05: e_br = (rs_data != rt_data);
                    6'h00: if (m_ir[5:0] == 6'h08) begin e_jr = 1'b1; e_jaddr = 32'(rs_data % 32); end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic settle();
        #1;
        model_eval();
        chk("pc_en", 32'(PC_EN), 32'(!e_hz));
        chk("ex_bubble", 32'(ex_bubble), 32'(e_hz));
        chk("j", 32'(J), 32'(e_j));
        chk("jal", 32'(JAL), 32'(e_jal));
        chk("jr", 32'(JR), 32'(e_jr));
        chk("branch", 32'(Branch), 32'(e_br));
        chk("jaddr", Jaddr, e_jaddr);
        chk("pc_branch", PC_branch, e_pcb);
        chk("id_ir", id_ir, m_ir);
        chk("id_valid", 32'(id_valid), 32'(m_valid));
        if (m_valid) chk("id_pc", id_pc, m_pc);
        chk("bubble_cnt", 32'(bubble_cnt), (m_bub > 65535) ? 32'hFFFF : 32'(m_bub));
    endtask

    task automatic tick();
        if (CLR) begin
            m_ir = 0; m_pc = 0; m_valid = 0; m_bub = 0;
        end else if (e_hz) begin
            m_bub++;
        end else if (e_j || e_jal || e_jr || e_br) begin
            m_ir = 0; m_valid = 0; m_pc = PC_in;
        end else begin
            m_ir = IR; m_pc = PC_in; m_valid = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_ir();
        logic [5:0] ops[9];
        logic [5:0] op, fn;
        ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h0F, 6'h23, 6'h2B, 6'h08};
        op = ops[$urandom_range(8)];
        fn = ($urandom_range(2) == 0) ? 6'h08 : 6'h20;
        return {op, 5'($urandom_range(7)), 5'($urandom_range(7)), 10'($urandom), fn};
    endfunction

    task automatic idle_inputs();
        CLR = 0; ex_mem_read = 0; ex_reg_write = 0; mem_mem_read = 0;
        ex_rd = 0; mem_rd = 0; rs_data = 0; rt_data = 0;
    endtask

    initial begin
        idle_inputs();
        IR = 0; PC_in = 0;
        m_ir = 0; m_pc = 0; m_valid = 0; m_bub = 0;
        e_hz = 0; e_j = 0; e_jal = 0; e_jr = 0; e_br = 0;
        @(negedge clk);

        // 1: reset, then addi enters IF/ID
        CLR = 1; tick();
        settle(); tick();
        CLR = 0; settle();
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_ir", id_ir, 32'd0);
        chk("rst_cnt", 32'(bubble_cnt), 32'd0);
        IR = 32'h2001_0005; PC_in = 0; tick();
        IR = 32'h0800_0010; PC_in = 1; settle();
        chk("t1_valid", 32'(id_valid), 32'd1);
        chk("t1_ir", id_ir, 32'h2001_0005);
        chk("t1_pcen", 32'(PC_EN), 32'd1);
        chk("t1_flags", {28'd0, J, JAL, JR, Branch}, 32'd0);
        tick();

        // 2: J 16 redirects, then the wrong-path fetch is squashed
        IR = 32'h2002_0001; PC_in = 2; settle();
        chk("t2_j", 32'(J), 32'd1);
        chk("t2_jaddr", Jaddr, 32'd16);
        tick();
        IR = 32'h1022_FFFE; PC_in = 8; settle();
        chk("t2_squash_valid", 32'(id_valid), 32'd0);
        chk("t2_squash_ir", id_ir, 32'd0);
        tick();

        // 3: BEQ $1,$2,-2 at pc 8
        rs_data = 7; rt_data = 7; IR = 32'h0065_2020; PC_in = 9; settle();
        chk("t3_taken", 32'(Branch), 32'd1);
        chk("t3_target", PC_branch, 32'd7);
        rt_data = 8; settle();
        chk("t3_not_taken", 32'(Branch), 32'd0);
        tick();

        // 4: load-use on add $4,$3,$5
        rs_data = 0; rt_data = 0;
        ex_mem_read = 1; ex_rd = 3; IR = 32'h0060_0008; PC_in = 10; settle();
        chk("t4_pcen", 32'(PC_EN), 32'd0);
        chk("t4_bubble", 32'(ex_bubble), 32'd1);
        tick();
        ex_mem_read = 0; settle();
        chk("t4_hold", id_ir, 32'h0065_2020);
        chk("t4_cnt", 32'(bubble_cnt), 32'd1);
        tick();

        // 5: JR $3 behind a load in EX, then a load in MEM
        ex_mem_read = 1; ex_rd = 3; rs_data = 32'h1234_5677; PC_in = 11; IR = 32'h0; settle();
        chk("t5_stall1", 32'(PC_EN), 32'd0);
        tick();
        ex_mem_read = 0; ex_rd = 0; mem_mem_read = 1; mem_rd = 3; settle();
        chk("t5_stall2", 32'(PC_EN), 32'd0);
        chk("t5_jr_held", 32'(JR), 32'd0);
        tick();
        mem_mem_read = 0; mem_rd = 0; settle();
        chk("t5_jr", 32'(JR), 32'd1);
        chk("t5_jaddr", Jaddr, 32'h17);
        chk("t5_cnt", 32'(bubble_cnt), 32'd3);
        IR = 32'h0000_2020; PC_in = 12; tick();
        settle(); tick();

        // 6: $0 never stalls
        ex_mem_read = 1; ex_rd = 0; settle();
        chk("t6_r0", 32'(PC_EN), 32'd1);
        tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            CLR          = ($urandom_range(39) == 0);
            IR           = rand_ir();
            PC_in        = $urandom;
            rs_data      = $urandom_range(3);
            rt_data      = ($urandom_range(1) == 0) ? rs_data : $urandom;
            if ($urandom_range(3) == 0) rs_data = $urandom;
            ex_mem_read  = ($urandom_range(3) == 0);
            ex_reg_write = ($urandom_range(1) == 0);
            mem_mem_read = ($urandom_range(3) == 0);
            ex_rd        = 5'($urandom_range(7));
            mem_rd       = 5'($urandom_range(7));
            settle(); tick();
        end

        // saturation: one stall held past 2^16 cycles
        idle_inputs(); CLR = 1; settle(); tick();
        CLR = 0; IR = 32'h0065_2020; PC_in = 20; settle(); tick();
        ex_mem_read = 1; ex_rd = 3;
        for (int i = 0; i < 65540; i++) begin
            settle(); tick();
        end
        settle();
        chk("sat_cnt", 32'(bubble_cnt), 32'hFFFF);

        // reset in the middle of a stall
        CLR = 1; tick();
        CLR = 0; settle();
        chk("rst_stall_valid", 32'(id_valid), 32'd0);
        chk("rst_stall_cnt", 32'(bubble_cnt), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
